// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative unsigned multiply/divide sequencer (divide path gated by MULDIV_DIV_EN)

module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic                hi_sel;   // op[0]: take the upper half of the working register
  logic [XLEN-1:0]     opnd;     // multiplicand for MUL/MULHU, divisor for DIVU/REMU
  logic [2*XLEN-1:0]   prod;     // {hi, lo}: product, or {remainder, quotient}

  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   step_next;

`ifdef MULDIV_DIV_EN
  logic                is_div;
  logic [XLEN:0]       div_diff;
`endif

  // One iteration of shift-add multiply or restoring divide on the working register
  always_comb begin
    mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    step_next = {mul_sum, prod[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
    // The shifted remainder needs XLEN+1 bits; the sign of the trial difference decides restore
    div_diff  = prod[2*XLEN-1:XLEN-1] - {1'b0, opnd};
    if (is_div) begin
      if (div_diff[XLEN]) begin
        step_next = {prod[2*XLEN-2:0], 1'b0};
      end else begin
        step_next = {div_diff[XLEN-1:0], prod[XLEN-2:0], 1'b1};
      end
    end
`endif
  end

  // Control FSM with registered busy/done/result and the iteration datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      hi_sel <= 1'b0;
      opnd   <= '0;
      prod   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
`ifdef MULDIV_DIV_EN
      is_div <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            hi_sel <= op[0];
            cnt    <= '0;
            busy   <= 1'b1;
            if (op[1]) begin
`ifdef MULDIV_DIV_EN
              is_div <= 1'b1;
              opnd   <= b;
              prod   <= {{XLEN{1'b0}}, a};
              if (b == '0) begin
                // Divide by zero resolves immediately: all ones quotient, dividend remainder
                state  <= DONE;
                done   <= 1'b1;
                result <= op[0] ? a : {XLEN{1'b1}};
              end else begin
                state  <= RUN;
              end
`else
              // No divider in this build: divide ops complete at once with a zero result
              state  <= DONE;
              done   <= 1'b1;
              result <= '0;
`endif
            end else begin
`ifdef MULDIV_DIV_EN
              is_div <= 1'b0;
`endif
              opnd  <= a;
              prod  <= {{XLEN{1'b0}}, b};
              state <= RUN;
            end
          end
        end

        RUN: begin
          prod <= step_next;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST_ITER) begin
            // Capture the final iteration's value directly so result is ready with done
            state  <= DONE;
            done   <= 1'b1;
            result <= hi_sel ? step_next[2*XLEN-1:XLEN] : step_next[XLEN-1:0];
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer with an arithmetic reference model

module tb_muldiv_sequencer;

  localparam int XLEN = 32;
  localparam int NORM_LAT = XLEN + 1;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  int checks;
  int failures;

  muldiv_sequencer #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result from plain arithmetic on the operation definitions
  function automatic logic [XLEN-1:0] model_result(input logic [1:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
    logic [2*XLEN-1:0] p;
    p = {{XLEN{1'b0}}, x} * {{XLEN{1'b0}}, y};
    case (o)
      2'b00: return p[XLEN-1:0];
      2'b01: return p[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
      2'b10: return (y == 0) ? {XLEN{1'b1}} : x / y;
      default: return (y == 0) ? x : x % y;
`else
      default: return '0;
`endif
    endcase
  endfunction

  // Reference cycles from accept edge to the cycle where done is seen
  function automatic int model_lat(input logic [1:0] o, input logic [XLEN-1:0] y);
`ifdef MULDIV_DIV_EN
    return (o[1] && y == 0) ? 1 : NORM_LAT;
`else
    return o[1] ? 1 : NORM_LAT;
`endif
  endfunction

  // Drive one request from a negedge, scramble inputs after accept, measure done and busy
  task automatic run_op(input logic [1:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                        output logic [XLEN-1:0] res, output int lat, output logic busy_mid,
                        output logic done_after, output logic busy_after);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    lat = -1; res = '0; busy_mid = 1'b0; done_after = 1'b1; busy_after = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) busy_mid = busy;
      if (done) begin
        lat = k;
        res = result;
        break;
      end
    end
    if (lat > 0) begin
      @(negedge clk);
      done_after = done;
      busy_after = busy;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (result !== '0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_release busy=%0b done=%0b exp=0/0", busy, done); end
  endtask

  task automatic test_mul_directed;
    logic [XLEN-1:0] res; int lat; logic bm, da, ba;
    logic [1:0] ops [3] = '{2'b00, 2'b01, 2'b00};
    logic [XLEN-1:0] xs [3] = '{32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [XLEN-1:0] ys [3] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [XLEN-1:0] ex [3] = '{32'h0000_002A, 32'hFFFF_FFFE, 32'h0000_0001};
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], xs[i], ys[i], res, lat, bm, da, ba);
      checks++; if (res !== ex[i]) begin failures++; $display("FAIL mul_dir%0d_result got=%h exp=%h", i, res, ex[i]); end
      checks++; if (lat != NORM_LAT) begin failures++; $display("FAIL mul_dir%0d_latency got=%0d exp=%0d", i, lat, NORM_LAT); end
      checks++; if (bm !== 1'b1 || da !== 1'b0 || ba !== 1'b0) begin failures++; $display("FAIL mul_dir%0d_handshake busy_mid=%0b done_after=%0b busy_after=%0b exp=1/0/0", i, bm, da, ba); end
    end
  endtask

  task automatic test_div_directed;
    logic [XLEN-1:0] res; int lat; logic bm, da, ba;
    logic [1:0] ops [4] = '{2'b10, 2'b11, 2'b10, 2'b11};
    logic [XLEN-1:0] xs [4] = '{32'd100, 32'd100, 32'h1234, 32'h1234};
    logic [XLEN-1:0] ys [4] = '{32'd7, 32'd7, 32'd0, 32'd0};
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], xs[i], ys[i], res, lat, bm, da, ba);
      checks++; if (res !== model_result(ops[i], xs[i], ys[i])) begin failures++; $display("FAIL div_dir%0d_result got=%h exp=%h", i, res, model_result(ops[i], xs[i], ys[i])); end
      checks++; if (lat != model_lat(ops[i], ys[i])) begin failures++; $display("FAIL div_dir%0d_latency got=%0d exp=%0d", i, lat, model_lat(ops[i], ys[i])); end
      checks++; if (bm !== 1'b1 || da !== 1'b0 || ba !== 1'b0) begin failures++; $display("FAIL div_dir%0d_handshake busy_mid=%0b done_after=%0b busy_after=%0b exp=1/0/0", i, bm, da, ba); end
    end
  endtask

  task automatic test_random;
    logic [XLEN-1:0] res, x, y; int lat; logic bm, da, ba; logic [1:0] o;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom);
      x = $urandom;
      case ($urandom_range(0, 3))
        0: y = '0;
        1: y = 32'($urandom_range(1, 255));
        default: y = $urandom;
      endcase
      run_op(o, x, y, res, lat, bm, da, ba);
      checks++; if (res !== model_result(o, x, y) || lat != model_lat(o, y)) begin
        failures++; $display("FAIL rand%0d op=%0d a=%h b=%h result got=%h exp=%h latency got=%0d exp=%0d", i, o, x, y, res, model_result(o, x, y), lat, model_lat(o, y));
      end
      checks++; if (da !== 1'b0 || ba !== 1'b0) begin failures++; $display("FAIL rand%0d_tail done_after=%0b busy_after=%0b exp=0/0", i, da, ba); end
    end
  endtask

  task automatic test_ignored_start;
    int lat; int extra;
    logic [XLEN-1:0] res;
    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1; res = '0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 10) begin start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7; end
      if (k == 11) start = 1'b0;
      if (done) begin lat = k; res = result; break; end
    end
    checks++; if (res !== 32'd15) begin failures++; $display("FAIL ignored_start_result got=%h exp=%h", res, 32'd15); end
    checks++; if (lat != NORM_LAT) begin failures++; $display("FAIL ignored_start_latency got=%0d exp=%0d", lat, NORM_LAT); end
    extra = 0;
    repeat (40) begin @(negedge clk); if (done || busy) extra++; end
    checks++; if (extra != 0) begin failures++; $display("FAIL ignored_start_no_followup got=%0d busy/done cycles exp=0", extra); end
  endtask

  task automatic test_reset_abort;
    int extra;
    logic [XLEN-1:0] res; int lat; logic bm, da, ba;
    start = 1'b1; op = 2'b01; a = $urandom | 32'h8000_0000; b = $urandom | 32'h8000_0000;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
      failures++; $display("FAIL reset_abort_async busy=%0b done=%0b result=%h exp=0/0/0", busy, done, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (45) begin @(negedge clk); if (done || busy) extra++; end
    checks++; if (extra != 0) begin failures++; $display("FAIL reset_abort_no_done got=%0d busy/done cycles exp=0", extra); end
    run_op(2'b00, 32'd9, 32'd11, res, lat, bm, da, ba);
    checks++; if (res !== 32'd99 || lat != NORM_LAT) begin failures++; $display("FAIL reset_abort_recover result got=%h exp=%h latency got=%0d exp=%0d", res, 32'd99, lat, NORM_LAT); end
  endtask

  task automatic test_back_to_back;
    logic [XLEN-1:0] res, x, y; int lat; logic bm, da, ba; logic [1:0] o;
    // run_op returns on the first busy=0 cycle, so each call accepts at the earliest legal edge
    for (int i = 0; i < 6; i++) begin
      o = 2'($urandom); x = $urandom; y = (i == 2) ? '0 : $urandom;
      run_op(o, x, y, res, lat, bm, da, ba);
      checks++; if (res !== model_result(o, x, y) || lat != model_lat(o, y) || ba !== 1'b0) begin
        failures++; $display("FAIL b2b%0d op=%0d result got=%h exp=%h latency got=%0d exp=%0d busy_after=%0b", i, o, res, model_result(o, x, y), lat, model_lat(o, y), ba);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_mul_directed();
    test_div_directed();
    test_random();
    test_ignored_start();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
